// File: rtl/ehl_jtag_master.sv
// ehl_jtag_master
// System-clock JTAG master. Takes one command at a time from a host and
// walks an IEEE 1149.1 TAP through it, starting and ending in Run-Test/Idle.
// TCK is generated from clk: each bit slot is DIV clks low, then DIV clks high.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready command handshake; operands latched at acceptance
//   cmd_op              00 TAP reset, 01 IR scan, 10 DR scan, 11 run-idle
//   cmd_len             scan bit count / run-idle TCK count (clamped to MAX_LEN)
//   cmd_data            scan data, bit 0 shifted first
//   rsp_valid           one-clk completion pulse
//   rsp_data            captured TDO, bit i = i-th shifted bit, upper bits 0
//   tck, tms, tdi, tdo  JTAG pins
module ehl_jtag_master #(
  parameter int DIV     = 2,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_HDR   = 3'd2,
    S_SHIFT = 3'd3,
    S_TRL   = 3'd4,
    S_RUN   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Number of TCK slots spent in a phase.
  function automatic logic [LEN_W-1:0] phase_len(input state_t st, input logic [1:0] op,
                                                 input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] n;
    case (st)
      S_RST:          n = LEN_W'(6);
      S_HDR:          n = (op == OP_IR) ? LEN_W'(4) : LEN_W'(3);
      S_SHIFT, S_RUN: n = len;
      S_TRL:          n = LEN_W'(2);
      default:        n = LEN_W'(1);
    endcase
    return n;
  endfunction

  // TMS value driven during slot 'idx' of a phase.
  function automatic logic slot_tms(input state_t st, input logic [LEN_W-1:0] idx,
                                    input logic [1:0] op, input logic [LEN_W-1:0] len);
    logic v;
    case (st)
      S_RST:   v = (idx < LEN_W'(5));
      S_HDR:   v = (op == OP_IR) ? (idx < LEN_W'(2)) : (idx == LEN_W'(0));
      S_SHIFT: v = (idx == len - LEN_W'(1));
      S_TRL:   v = (idx == LEN_W'(0));
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Phase that follows the last slot of the current one.
  function automatic state_t next_phase(input state_t st);
    state_t n;
    case (st)
      S_HDR:   n = S_SHIFT;
      S_SHIFT: n = S_TRL;
      default: n = S_DONE;
    endcase
    return n;
  endfunction

  state_t             state_r, state_n;
  logic               tck_r, tck_n;
  logic               tms_r, tms_n;
  logic               tdi_r, tdi_n;
  logic [DIV_W-1:0]   div_cnt_r, div_cnt_n;
  logic [LEN_W-1:0]   bit_cnt_r, bit_cnt_n;
  logic [1:0]         op_r, op_n;
  logic [LEN_W-1:0]   len_r, len_n;
  logic [MAX_LEN-1:0] data_r, data_n;
  logic [MAX_LEN-1:0] cap_r, cap_n;
  logic               rsp_valid_r, rsp_valid_n;
  logic [MAX_LEN-1:0] rsp_data_r, rsp_data_n;
  logic               cmd_ready_r, cmd_ready_n;
  logic               load_slot_s;
  logic               last_bit_s;
  logic [LEN_W-1:0]   len_clamp_s;

  assign len_clamp_s = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign last_bit_s  = (bit_cnt_r == phase_len(state_r, op_r, len_r) - LEN_W'(1));

  // Next-state, TCK slot sequencing and capture logic.
  always_comb begin
    state_n     = state_r;
    tck_n       = tck_r;
    tms_n       = tms_r;
    tdi_n       = tdi_r;
    div_cnt_n   = div_cnt_r;
    bit_cnt_n   = bit_cnt_r;
    op_n        = op_r;
    len_n       = len_r;
    data_n      = data_r;
    cap_n       = cap_r;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data_r;
    cmd_ready_n = cmd_ready_r;
    load_slot_s = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_ready_n = 1'b0;
          op_n        = cmd_op;
          len_n       = len_clamp_s;
          data_n      = cmd_data;
          cap_n       = '0;
          bit_cnt_n   = LEN_W'(0);
          div_cnt_n   = DIV_W'(0);
          tck_n       = 1'b0;
          if (cmd_op == OP_RESET) begin
            state_n     = S_RST;
            load_slot_s = 1'b1;
          end else if (len_clamp_s == LEN_W'(0)) begin
            // Zero-length scan or run: no slots, pass through RUN once so the
            // response lands two clks after acceptance.
            state_n = S_RUN;
          end else if (cmd_op == OP_RUN) begin
            state_n     = S_RUN;
            load_slot_s = 1'b1;
          end else begin
            state_n     = S_HDR;
            load_slot_s = 1'b1;
          end
        end else begin
          cmd_ready_n = 1'b1;
        end
      end

      S_RST, S_HDR, S_SHIFT, S_TRL, S_RUN: begin
        if ((state_r == S_RUN) && (len_r == LEN_W'(0))) begin
          state_n = S_DONE;
        end else if (div_cnt_r == DIV_W'(DIV - 1)) begin
          div_cnt_n = DIV_W'(0);
          tck_n     = ~tck_r;
          if (!tck_r) begin
            // Rising TCK: the TAP's TDO was set up on the previous fall.
            if (state_r == S_SHIFT) begin
              cap_n[bit_cnt_r[IDX_W-1:0]] = tdo;
            end else begin
              cap_n = cap_r;
            end
          end else if (last_bit_s) begin
            bit_cnt_n = LEN_W'(0);
            state_n   = next_phase(state_r);
            if (state_n != S_DONE) begin
              load_slot_s = 1'b1;
            end else begin
              load_slot_s = 1'b0;
            end
          end else begin
            bit_cnt_n   = bit_cnt_r + LEN_W'(1);
            load_slot_s = 1'b1;
          end
        end else begin
          div_cnt_n = div_cnt_r + DIV_W'(1);
        end
      end

      S_DONE: begin
        state_n     = S_IDLE;
        rsp_valid_n = 1'b1;
        rsp_data_n  = cap_r;
        cmd_ready_n = 1'b1;
      end

      default: begin
        state_n     = S_IDLE;
        cmd_ready_n = 1'b1;
      end
    endcase

    // TMS/TDI only change at the start of a slot (TCK low).
    if (load_slot_s) begin
      tms_n = slot_tms(state_n, bit_cnt_n, op_n, len_n);
      tdi_n = (state_n == S_SHIFT) ? data_n[bit_cnt_n[IDX_W-1:0]] : 1'b0;
    end else begin
      tms_n = tms_r;
      tdi_n = tdi_r;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      tck_r       <= 1'b0;
      tms_r       <= 1'b1;
      tdi_r       <= 1'b0;
      div_cnt_r   <= '0;
      bit_cnt_r   <= '0;
      op_r        <= 2'b00;
      len_r       <= '0;
      data_r      <= '0;
      cap_r       <= '0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      cmd_ready_r <= 1'b1;
    end else begin
      state_r     <= state_n;
      tck_r       <= tck_n;
      tms_r       <= tms_n;
      tdi_r       <= tdi_n;
      div_cnt_r   <= div_cnt_n;
      bit_cnt_r   <= bit_cnt_n;
      op_r        <= op_n;
      len_r       <= len_n;
      data_r      <= data_n;
      cap_r       <= cap_n;
      rsp_valid_r <= rsp_valid_n;
      rsp_data_r  <= rsp_data_n;
      cmd_ready_r <= cmd_ready_n;
    end
  end

  assign tck       = tck_r;
  assign tms       = tms_r;
  assign tdi       = tdi_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign cmd_ready = cmd_ready_r;

endmodule

// File: tb/tb_ehl_jtag_master.sv
// Testbench for ehl_jtag_master. A small behavioural TAP (2-bit IR, IDCODE and
// BYPASS) is attached to the JTAG pins; a vector table drives commands and
// checks pulse count, TMS/TDI sequences, latency, response and TAP state.
module tb_ehl_jtag_master;

  localparam int DIV     = 2;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  localparam logic [31:0] ID_VAL     = 32'h1234_5677;
  localparam logic [1:0]  IR_IDCODE  = 2'b10;
  localparam logic [1:0]  IR_BYPASS  = 2'b11;

  typedef enum logic [3:0] {
    TLR, RTI, SDR, CDR, SHD, E1D, PDR, E2D, UDR, SIR, CIR, SHI, E1I, PIR, E2I, UIR
  } tap_t;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] data;
    int          pulses;
    logic [63:0] tms_seq;
    logic [63:0] tdi_seq;
    logic [31:0] rsp;
    tap_t        st;
    logic [1:0]  ir;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               tck;
  logic               tms;
  logic               tdi;
  logic               tdo = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ehl_jtag_master #(.DIV(DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  // ---------------- behavioural TAP ----------------
  tap_t        tap_st    = PDR;
  logic [1:0]  ir        = IR_IDCODE;
  logic [1:0]  ir_sr     = 2'b00;
  logic [31:0] dr_sr     = 32'h0;
  logic        byp       = 1'b0;
  logic        tlr_seen  = 1'b0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR: return m ? TLR : RTI;
      RTI: return m ? SDR : RTI;
      SDR: return m ? SIR : CDR;
      CDR: return m ? E1D : SHD;
      SHD: return m ? E1D : SHD;
      E1D: return m ? UDR : PDR;
      PDR: return m ? E2D : PDR;
      E2D: return m ? UDR : SHD;
      UDR: return m ? SDR : RTI;
      SIR: return m ? TLR : CIR;
      CIR: return m ? E1I : SHI;
      SHI: return m ? E1I : SHI;
      E1I: return m ? UIR : PIR;
      PIR: return m ? E2I : PIR;
      E2I: return m ? UIR : SHI;
      UIR: return m ? SDR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap_st)
      TLR: ir <= IR_IDCODE;
      CDR: if (ir == IR_IDCODE) dr_sr <= ID_VAL; else byp <= 1'b0;
      SHD: if (ir == IR_IDCODE) dr_sr <= {tdi, dr_sr[31:1]}; else byp <= tdi;
      CIR: ir_sr <= 2'b01;
      SHI: ir_sr <= {tdi, ir_sr[1]};
      UIR: ir <= ir_sr;
      default: ;
    endcase
    if (tap_st == TLR) tlr_seen <= 1'b1;
    tap_st <= tap_next(tap_st, tms);
  end

  always @(negedge tck) begin
    case (tap_st)
      SHD:     tdo <= (ir == IR_IDCODE) ? dr_sr[0] : byp;
      SHI:     tdo <= ir_sr[0];
      default: tdo <= 1'b0;
    endcase
  end

  // ---------------- pin monitors ----------------
  logic [15:0] tck_total = 16'd0;
  bit          tms_log [0:1023];
  bit          tdi_log [0:1023];

  always @(posedge tck) begin
    tms_log[tck_total[9:0]] <= tms;
    tdi_log[tck_total[9:0]] <= tdi;
    tck_total <= tck_total + 16'd1;
  end

  int   hi_run   = 0;
  int   hi_err   = 0;
  int   stab_err = 0;
  logic prev_tck = 1'b0, prev_tms = 1'b0, prev_tdi = 1'b0;

  always @(negedge clk) begin
    if (tck === 1'b1) begin
      hi_run <= hi_run + 1;
    end else begin
      if (hi_run != 0 && hi_run != DIV) hi_err <= hi_err + 1;
      hi_run <= 0;
    end
    if (tck === 1'b1 && prev_tck === 1'b1 && (tms !== prev_tms || tdi !== prev_tdi))
      stab_err <= stab_err + 1;
    prev_tck <= tck;
    prev_tms <= tms;
    prev_tdi <= tdi;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic wait_ready(input string name);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cmd_ready !== 1'b1) timeout_fail(name);
  endtask

  // Waits (from the negedge after acceptance) for rsp_valid; returns clks elapsed.
  task automatic wait_rsp(input string name, output int cyc, output bit ok);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    ok = (rsp_valid === 1'b1);
    if (!ok) timeout_fail(name);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] base;
    logic [63:0] tms_act, tdi_act;
    int          cyc, exp_lat, np;
    bit          ok;
    wait_ready({tag, " ready"});
    base      = tck_total;
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_len   = v.len;
    cmd_data  = v.data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_len   = 6'd0;
    cmd_data  = 32'h0;
    wait_rsp({tag, " rsp"}, cyc, ok);
    if (ok) begin
      exp_lat = (v.pulses == 0) ? 2 : v.pulses * 2 * DIV + 1;
      check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
      check({tag, " rsp_data"}, 64'(rsp_data), 64'(v.rsp));
      check({tag, " ready_at_rsp"}, 64'(cmd_ready), 64'd1);
      @(negedge clk);
      check({tag, " rsp_pulse_width"}, 64'(rsp_valid), 64'd0);
      np = int'(tck_total - base);
      check({tag, " tck_pulses"}, 64'(np), 64'(v.pulses));
      tms_act = 64'h0;
      tdi_act = 64'h0;
      for (int k = 0; k < 64; k++) begin
        if (k < np) begin
          tms_act[k] = tms_log[10'(base + 16'(k))];
          tdi_act[k] = tdi_log[10'(base + 16'(k))];
        end
      end
      check({tag, " tms_seq"}, tms_act, v.tms_seq);
      check({tag, " tdi_seq"}, tdi_act, v.tdi_seq);
      check({tag, " tap_state"}, 64'(tap_st), 64'(v.st));
      check({tag, " tap_ir"}, 64'(ir), 64'(v.ir));
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs [0:8];

  initial begin : main
    int  cyc;
    bit  ok;
    int  np;
    int  rsp_cnt;
    logic [15:0] base;

    vecs[0] = '{op: 2'b00, len: 6'd0,  data: 32'h0,         pulses: 6,  tms_seq: 64'h1F,
                tdi_seq: 64'h0,          rsp: 32'h0,         st: RTI, ir: IR_IDCODE};
    vecs[1] = '{op: 2'b10, len: 6'd32, data: 32'h0,         pulses: 37, tms_seq: 64'hC_0000_0001,
                tdi_seq: 64'h0,          rsp: ID_VAL,        st: RTI, ir: IR_IDCODE};
    vecs[2] = '{op: 2'b10, len: 6'd16, data: 32'h0,         pulses: 21, tms_seq: 64'hC_0001,
                tdi_seq: 64'h0,          rsp: 32'h0000_5677, st: RTI, ir: IR_IDCODE};
    vecs[3] = '{op: 2'b01, len: 6'd2,  data: 32'h3,         pulses: 8,  tms_seq: 64'h63,
                tdi_seq: 64'h30,         rsp: 32'h1,         st: RTI, ir: IR_BYPASS};
    vecs[4] = '{op: 2'b10, len: 6'd8,  data: 32'hA5,        pulses: 13, tms_seq: 64'hC01,
                tdi_seq: 64'h528,        rsp: 32'h4A,        st: RTI, ir: IR_BYPASS};
    vecs[5] = '{op: 2'b11, len: 6'd3,  data: 32'h0,         pulses: 3,  tms_seq: 64'h0,
                tdi_seq: 64'h0,          rsp: 32'h0,         st: RTI, ir: IR_BYPASS};
    vecs[6] = '{op: 2'b11, len: 6'd0,  data: 32'h0,         pulses: 0,  tms_seq: 64'h0,
                tdi_seq: 64'h0,          rsp: 32'h0,         st: RTI, ir: IR_BYPASS};
    vecs[7] = '{op: 2'b10, len: 6'd40, data: 32'hFFFF_FFFF, pulses: 37, tms_seq: 64'hC_0000_0001,
                tdi_seq: 64'h7_FFFF_FFF8, rsp: 32'hFFFF_FFFE, st: RTI, ir: IR_BYPASS};
    vecs[8] = '{op: 2'b01, len: 6'd0,  data: 32'h3,         pulses: 0,  tms_seq: 64'h0,
                tdi_seq: 64'h0,          rsp: 32'h0,         st: RTI, ir: IR_BYPASS};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 6'd0;
    cmd_data  = 32'h0;
    repeat (3) @(negedge clk);
    check("reset tck", 64'(tck), 64'd0);
    check("reset tms", 64'(tms), 64'd1);
    check("reset tdi", 64'(tdi), 64'd0);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_data", 64'(rsp_data), 64'd0);
    check("reset cmd_ready", 64'(cmd_ready), 64'd1);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end
    check("tlr_seen", 64'(tlr_seen), 64'd1);

    // Held cmd_valid while busy is ignored; accept in the rsp_valid clk.
    wait_ready("b2b ready");
    base      = tck_total;
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_len   = 6'd1;
    @(negedge clk);
    cmd_len = 6'd5;
    wait_rsp("b2b rsp1", cyc, ok);
    if (ok) begin
      check("b2b latency1", 64'(cyc), 64'(1 * 2 * DIV + 1));
      np = int'(tck_total - base);
      check("b2b pulses1", 64'(np), 64'd1);
      cmd_len = 6'd2;
      base    = tck_total;
      @(negedge clk);
      check("b2b accepted", 64'(cmd_ready), 64'd0);
      check("b2b rsp_dropped", 64'(rsp_valid), 64'd0);
      cmd_valid = 1'b0;
      wait_rsp("b2b rsp2", cyc, ok);
      if (ok) begin
        check("b2b latency2", 64'(cyc), 64'(2 * 2 * DIV + 1));
        np = int'(tck_total - base);
        check("b2b pulses2", 64'(np), 64'd2);
      end
    end
    cmd_valid = 1'b0;

    // Reset while shifting a 32-bit DR scan aborts without a response.
    wait_ready("abort ready");
    base      = tck_total;
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = 6'd32;
    cmd_data  = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (!(tap_st == SHD && (tck_total - base) >= 16'd8 && tck === 1'b0) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 500) timeout_fail("abort reach shift");
    rst = 1'b1;
    @(negedge clk);
    check("abort tck", 64'(tck), 64'd0);
    check("abort tms", 64'(tms), 64'd1);
    check("abort cmd_ready", 64'(cmd_ready), 64'd1);
    check("abort rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    rsp_cnt = 0;
    base    = tck_total;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) rsp_cnt++;
    end
    check("abort no_rsp", 64'(rsp_cnt), 64'd0);
    np = int'(tck_total - base);
    check("abort tck_quiet", 64'(np), 64'd0);

    run_vec(vecs[0], "post_abort reset");
    run_vec(vecs[1], "post_abort idcode");

    check("tck high width", 64'(hi_err), 64'd0);
    check("tms/tdi stable while tck high", 64'(stab_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
